// File: rtl/lfsr_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_seq_checker
// Brief    : Self-synchronising checker for a 5-bit Galois LFSR sample stream.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_seq_checker #(
  parameter int LOCK_MATCHES  = 4,
  parameter int UNLOCK_MISSES = 3,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [4:0]       in_state,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       fsm_state
);

  localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
  localparam int MISS_W  = $clog2(UNLOCK_MISSES + 1);
  localparam logic [MATCH_W-1:0] c_match_last = MATCH_W'(LOCK_MATCHES - 1);
  localparam logic [MISS_W-1:0]  c_miss_last  = MISS_W'(UNLOCK_MISSES - 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             r_state;
  logic [4:0]         r_ref;
  logic [MATCH_W-1:0] r_match_cnt;
  logic [MISS_W-1:0]  r_miss_cnt;

  logic [4:0] w_next_in;
  logic [4:0] w_next_ref;
  logic       w_hit;
  logic       w_err;

  function automatic logic [4:0] lfsr_next(input logic [4:0] s);
    return {s[0], s[4], s[3] ^ s[0], s[2], s[1]};
  endfunction

  assign w_next_in  = lfsr_next(in_state);
  assign w_next_ref = lfsr_next(r_ref);
  assign w_hit      = (in_state == r_ref);
  assign w_err      = in_valid && (r_state == ST_LOCKED) && !w_hit;
  assign fsm_state  = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_HUNT;
      r_ref       <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        case (r_state)
          ST_HUNT: begin
            // An all-zero sample is the LFSR lock-up state and cannot seed anything.
            if (in_state != 5'h00) begin
              r_ref       <= w_next_in;
              r_match_cnt <= '0;
              r_state     <= ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            if (w_hit) begin
              r_ref <= w_next_ref;
              if (r_match_cnt == c_match_last) begin
                r_state     <= ST_LOCKED;
                locked      <= 1'b1;
                r_miss_cnt  <= '0;
                r_match_cnt <= '0;
              end else begin
                r_match_cnt <= r_match_cnt + MATCH_W'(1);
              end
            end else if (in_state == 5'h00) begin
              r_match_cnt <= '0;
              r_state     <= ST_HUNT;
            end else begin
              r_ref       <= w_next_in;
              r_match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            // Flywheel: once locked the reference never follows the input.
            r_ref <= w_next_ref;
            if (w_hit) begin
              r_miss_cnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (r_miss_cnt == c_miss_last) begin
                r_miss_cnt <= '0;
                r_state    <= ST_HUNT;
                locked     <= 1'b0;
              end else begin
                r_miss_cnt <= r_miss_cnt + MISS_W'(1);
              end
            end
          end
          default: begin
            r_state <= ST_HUNT;
            locked  <= 1'b0;
          end
        endcase
      end

      // Clear takes priority over a coincident increment.
      if (clr_cnt) begin
        err_count <= '0;
      end else if (w_err && (err_count != {CNT_W{1'b1}})) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_seq_checker
// Brief    : Directed self-checking bench for lfsr_seq_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_seq_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_state = 5'h00;
  logic        clr_cnt = 1'b0;

  logic        locked,    s_locked;
  logic        err_pulse, s_err_pulse;
  logic [15:0] err_count;
  logic [1:0]  s_err_count;
  logic [1:0]  fsm_state, s_fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  // Full period of the LFSR starting at 5'h01, worked out by hand.
  logic [4:0] seq [31] = '{
    5'h01, 5'h14, 5'h0A, 5'h05, 5'h16, 5'h0B, 5'h11, 5'h1C, 5'h0E, 5'h07,
    5'h17, 5'h1F, 5'h1B, 5'h19, 5'h18, 5'h0C, 5'h06, 5'h03, 5'h15, 5'h1E,
    5'h0F, 5'h13, 5'h1D, 5'h1A, 5'h0D, 5'h12, 5'h09, 5'h10, 5'h08, 5'h04,
    5'h02
  };

  always #5 clk = ~clk;

  lfsr_seq_checker #(.LOCK_MATCHES(4), .UNLOCK_MISSES(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_state(in_state), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .fsm_state(fsm_state)
  );

  lfsr_seq_checker #(.LOCK_MATCHES(4), .UNLOCK_MISSES(3), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_state(in_state), .clr_cnt(clr_cnt),
    .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count),
    .fsm_state(s_fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one cycle of stimulus; outputs are sampled 1 ns after the edge.
  task automatic send(input logic v, input logic [4:0] s, input logic c = 1'b0);
    in_valid = v;
    in_state = s;
    clr_cnt  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    check("rst locked", locked, 0);
    check("rst err_pulse", err_pulse, 0);
    check("rst err_count", err_count, 0);
    check("rst fsm_state", fsm_state, 0);
    rst = 1'b1;
    send(0, 5'h00);

    // Acquire lock on a clean stream
    send(1, seq[0]);
    check("t1 verify", fsm_state, 1);
    for (int i = 1; i < 4; i++) send(1, seq[i]);
    check("t1 not yet locked", locked, 0);
    send(1, seq[4]);
    check("t1 locked", locked, 1);
    check("t1 fsm locked", fsm_state, 2);
    check("t1 err_count", err_count, 0);

    // Single corrupted sample
    send(1, 5'h0C);
    check("t2 err_pulse", err_pulse, 1);
    check("t2 err_count", err_count, 1);
    check("t2 locked", locked, 1);
    send(1, seq[6]);
    check("t2 pulse clears", err_pulse, 0);
    check("t2 count holds", err_count, 1);

    // Two misses then a hit must restart the miss run
    send(1, 5'h1F);
    send(1, 5'h1F);
    check("t3 two misses locked", locked, 1);
    send(1, seq[9]);
    check("t3 hit err_pulse", err_pulse, 0);
    check("t3 hit count", err_count, 3);
    send(0, 5'h00, 1'b1);
    check("t3 clr", err_count, 0);
    send(1, 5'h00);
    send(1, 5'h00);
    check("t3 miss2 locked", locked, 1);
    send(1, 5'h00);
    check("t3 unlock locked", locked, 0);
    check("t3 unlock fsm", fsm_state, 0);
    check("t3 unlock pulse", err_pulse, 1);
    check("t3 unlock count", err_count, 3);

    // Zeros ignored in HUNT; reseed inside VERIFY
    send(1, 5'h00);
    send(1, 5'h00);
    check("t4 zeros hunt", fsm_state, 0);
    send(1, 5'h01);
    send(1, 5'h14);
    send(1, 5'h1F);
    check("t4 reseed fsm", fsm_state, 1);
    check("t4 reseed pulse", err_pulse, 0);
    send(1, 5'h1B);
    send(1, 5'h19);
    send(1, 5'h18);
    check("t4 pre-lock", locked, 0);
    send(1, 5'h0C);
    check("t4 relocked", locked, 1);
    check("t4 count", err_count, 3);

    // Saturation with a 2-bit counter, then clear against a coincident error
    send(0, 5'h00, 1'b1);
    check("t5 clr sat", s_err_count, 0);
    for (int e = 0; e < 5; e++) begin
      send(1, 5'h00);
      check("t5 err pulse", s_err_pulse, 1);
      check("t5 sat count", s_err_count, (e < 3) ? e + 1 : 3);
      send(1, seq[17 + 2 * e]);
      check("t5 still locked", s_locked, 1);
    end
    check("t5 wide count", err_count, 5);
    send(1, 5'h00, 1'b1);
    check("t5 clr+err pulse", err_pulse, 1);
    check("t5 clr+err count", err_count, 0);
    check("t5 clr+err sat count", s_err_count, 0);
    send(1, seq[27]);
    check("t5 after clr locked", locked, 1);

    // Gaps in in_valid are transparent
    k = 28;
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        send(0, 5'h1F);
        check("t6 gap pulse", err_pulse, 0);
      end
      send(1, seq[k]);
      check("t6 valid pulse", err_pulse, 0);
      k = (k + 1) % 31;
    end
    check("t6 gap locked", locked, 1);
    check("t6 gap count", err_count, 0);

    // Asynchronous reset mid-stream, then relock
    send(1, 5'h00);
    check("t6 pre-rst count", err_count, 1);
    rst = 1'b0;
    #2;
    check("t6 async locked", locked, 0);
    check("t6 async pulse", err_pulse, 0);
    check("t6 async count", err_count, 0);
    check("t6 async fsm", fsm_state, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) send(1, seq[(3 + i) % 31]);
    check("t6 relock early", locked, 0);
    send(1, seq[7]);
    check("t6 relock", locked, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
